// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding, default width
// and the bit-counter sizing helper.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter must be able to hold the value WIDTH itself, not just WIDTH-1.
  function automatic int cnt_bits(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder used as the serial bit slice.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);

  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in one bit per
// clock, LSB first, and presents a registered sum, carry-out and signed
// overflow flag together with a one-cycle done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = cnt_bits(WIDTH);
  localparam logic [CW-1:0] CNT_END = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           next_state_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  // Holds result bits 0..WIDTH-2; the MSB comes straight from the slice
  // on the final edge, so one bit less of storage is needed.
  logic [WIDTH-2:0] sum_sh_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;

  logic             fa_sum_s;
  logic             fa_carry_s;
  logic [CW-1:0]    cnt_inc_s;
  logic             accept_s;
  logic             last_s;
  logic [WIDTH-1:0] sum_next_s;

  full_adder u_fa (
    .x (a_sh_r[0]),
    .y (b_sh_r[0]),
    .z (carry_r),
    .s (fa_sum_s),
    .c (fa_carry_s)
  );

  assign cnt_inc_s  = cnt_r + CNT_ONE;
  assign accept_s   = start && ((state_r == IDLE) || (state_r == DONE));
  assign last_s     = (state_r == SHIFT) && (cnt_inc_s == CNT_END);
  assign sum_next_s = {fa_sum_s, sum_sh_r};

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; start is only honoured in IDLE or DONE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = SHIFT;
        end else begin
          next_state_s = IDLE;
        end
      end
      SHIFT: begin
        if (last_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = SHIFT;
        end
      end
      DONE: begin
        if (start) begin
          next_state_s = SHIFT;
        end else begin
          next_state_s = IDLE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Operand capture and per-bit shifting of operands, partial sum and carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      sum_sh_r <= {(WIDTH-1){1'b0}};
      carry_r  <= 1'b0;
      cnt_r    <= {CW{1'b0}};
    end else if (accept_s) begin
      a_sh_r   <= a;
      b_sh_r   <= b;
      carry_r  <= cin;
      cnt_r    <= {CW{1'b0}};
    end else if (state_r == SHIFT) begin
      a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
      b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
      sum_sh_r <= sum_next_s[WIDTH-1:1];
      carry_r  <= fa_carry_s;
      cnt_r    <= cnt_inc_s;
    end else begin
      cnt_r    <= cnt_r;
    end
  end

  // Flopped status and result outputs; results only change on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      sum  <= {WIDTH{1'b0}};
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      busy <= (next_state_s == SHIFT);
      done <= (next_state_s == DONE);
      if (last_s) begin
        sum  <= sum_next_s;
        cout <= fa_carry_s;
        ovf  <= carry_r ^ fa_carry_s;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes expected results and
// completion cycles into queues; negedge monitors compare every cycle.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;

  logic       start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          done_cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  exp_t last8, last4;
  int   cyc = 0;
  logic rst_q = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic eb8, ed8, eb4, ed4;

  // Reference: plain integer arithmetic, signed overflow from range check.
  function automatic exp_t model(input int w, input int a, input int b,
                                 input int c, input int dc);
    exp_t   e;
    longint m, half, total, sa, sb, sr;
    m     = longint'(1) << w;
    half  = m / 2;
    total = longint'(a) + longint'(b) + longint'(c);
    e.sum  = 32'(total % m);
    e.cout = (total >= m);
    sa = (longint'(a) >= half) ? longint'(a) - m : longint'(a);
    sb = (longint'(b) >= half) ? longint'(b) - m : longint'(b);
    sr = sa + sb + longint'(c);
    e.ovf = (sr >= half) || (sr < -half);
    e.done_cyc = dc;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Cycle counter and registered copy of reset for the monitors.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (rst_q) begin
      q8.delete();
      last8 = '{sum: 32'd0, cout: 1'b0, ovf: 1'b0, done_cyc: 0};
      chk("rst_busy8", 32'(busy8), 32'd0);
      chk("rst_done8", 32'(done8), 32'd0);
    end else begin
      eb8 = (q8.size() > 0) && (cyc < q8[0].done_cyc);
      ed8 = (q8.size() > 0) && (cyc == q8[0].done_cyc);
      chk("busy8", 32'(busy8), 32'(eb8));
      chk("done8", 32'(done8), 32'(ed8));
      if (ed8) begin
        last8 = q8.pop_front();
      end else if ((q8.size() > 0) && (cyc > q8[0].done_cyc)) begin
        void'(q8.pop_front());
      end
    end
    chk("sum8", 32'(sum8), last8.sum);
    chk("cout8", 32'(cout8), 32'(last8.cout));
    chk("ovf8", 32'(ovf8), 32'(last8.ovf));
  end

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin
    if (rst_q) begin
      q4.delete();
      last4 = '{sum: 32'd0, cout: 1'b0, ovf: 1'b0, done_cyc: 0};
      chk("rst_busy4", 32'(busy4), 32'd0);
      chk("rst_done4", 32'(done4), 32'd0);
    end else begin
      eb4 = (q4.size() > 0) && (cyc < q4[0].done_cyc);
      ed4 = (q4.size() > 0) && (cyc == q4[0].done_cyc);
      chk("busy4", 32'(busy4), 32'(eb4));
      chk("done4", 32'(done4), 32'(ed4));
      if (ed4) begin
        last4 = q4.pop_front();
      end else if ((q4.size() > 0) && (cyc > q4[0].done_cyc)) begin
        void'(q4.pop_front());
      end
    end
    chk("sum4", 32'(sum4), last4.sum);
    chk("cout4", 32'(cout4), 32'(last4.cout));
    chk("ovf4", 32'(ovf4), 32'(last4.ovf));
  end

  task automatic issue8(input int a, input int b, input int c);
    start8 = 1'b1;
    a8     = 8'(a);
    b8     = 8'(b);
    cin8   = 1'(c);
    @(posedge clk); #1;
    q8.push_back(model(8, a, b, c, cyc + 8));
    start8 = 1'b0;
  endtask

  task automatic issue4(input int a, input int b, input int c);
    start4 = 1'b1;
    a4     = 4'(a);
    b4     = 4'(b);
    cin4   = 1'(c);
    @(posedge clk); #1;
    q4.push_back(model(4, a, b, c, cyc + 4));
    start4 = 1'b0;
  endtask

  task automatic wait_idle8();
    int n = 0;
    while ((q8.size() > 0) && (n < 100)) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle8_timeout", 32'(q8.size()), 32'd0);
  endtask

  task automatic wait_idle4();
    int n = 0;
    while ((q4.size() > 0) && (n < 100)) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle4_timeout", 32'(q4.size()), 32'd0);
  endtask

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  // Stimulus.
  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = 8'd0; b8 = 8'd0; cin8 = 1'b0;
    start4 = 1'b0; a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Basic and boundary additions.
    issue8(3, 5, 0);    wait_idle8();
    issue8(255, 1, 0);  wait_idle8();
    issue8(127, 1, 0);  wait_idle8();
    issue8(0, 0, 1);    wait_idle8();

    // Start pulse during busy must be ignored.
    issue8(10, 20, 0);
    repeat (2) @(posedge clk);
    #1;
    start8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_idle8();

    // Back-to-back: start held during the DONE cycle.
    issue8(7, 9, 0);
    repeat (8) @(posedge clk);
    #1;
    issue8(100, 50, 0);
    wait_idle8();

    // Reset on the fourth SHIFT edge aborts; next op must be clean.
    issue8(50, 60, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    issue8(200, 100, 0);
    wait_idle8();

    // Reset wins over a simultaneous start.
    rst = 1'b1; start8 = 1'b1; a8 = 8'd9; b8 = 8'd9;
    @(posedge clk); #1;
    rst = 1'b0; start8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    // Random operations with random noise on start while busy.
    for (int i = 0; i < 40; i++) begin
      issue8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 1)));
      for (int j = 0; j < 8; j++) begin
        start8 = 1'($urandom_range(0, 1));
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        @(posedge clk); #1;
      end
      start8 = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_idle8();

    // Exhaustive 4-bit sweep, back-to-back.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          issue4(a, b, c);
          repeat (4) @(posedge clk);
          #1;
        end
      end
    end
    wait_idle4();

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
